// File: rtl/fft_unload.sv
`default_nettype none
// ============================================================================
// Module   : fft_unload
// Purpose  : Output-side consumer for the corefft streaming FFT. Captures the
//            core's result stream into a two-bank ping-pong frame buffer and
//            replays each completed frame in natural bin order over a
//            valid/ready stream, so downstream backpressure never stalls
//            the FFT core.
// Ports    : clk, areset (sync, active-high)
//            in_en / in_cnt / in_re / in_im   - corefft dout_* result stream
//            out_valid / out_ready            - output handshake
//            out_re / out_im / out_idx / out_last - registered output beat
//            ovf      - sticky, a frame was dropped for lack of a free bank
//            sync_err - one-cycle pulse when a frame aborts on an index gap
// Config   : FFT_UNLOAD_BITREV_EN - write address is bitrev(in_cnt) for a
//            core emitting bit-reversed order; undefined = natural order.
// Revision : 1.0 - initial release
// ============================================================================
module fft_unload #(
    parameter int width = 16,
    parameter int N     = 9
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             in_en,
    input  logic [N-1:0]     in_cnt,
    input  logic [width-1:0] in_re,
    input  logic [width-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_re,
    output logic [width-1:0] out_im,
    output logic [N-1:0]     out_idx,
    output logic             out_last,
    output logic             ovf,
    output logic             sync_err
);

    localparam int             c_WORDS    = 2 * (2 ** N);
    localparam logic [N-1:0]   c_LAST_IDX = '1;
    localparam logic [N-1:0]   c_ONE      = N'(1);

    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_PRIME  = 2'd1,
        RD_STREAM = 2'd2
    } rd_state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [2*width-1:0] r_mem [0:c_WORDS-1];

    bank_state_t        r_bank [2];
    bank_state_t        w_bank_nxt [2];

    logic               r_wr_ptr, w_wr_ptr_nxt;
    logic               r_filling, w_filling_nxt;
    logic [N-1:0]       r_exp_cnt, w_exp_cnt_nxt;
    logic [N-1:0]       w_wr_addr;
    logic               w_we, w_abort, w_drop;

    rd_state_t          r_rd_state, w_rd_state_nxt;
    logic               r_rd_ptr;
    logic [N-1:0]       r_rd_addr, w_rd_addr;
    logic               w_rd_issue, w_rd_release;

    logic [2*width-1:0] r_rd_data;
    logic [N-1:0]       r_rd_idx;
    logic               r_rd_vld;

    logic               r_out_valid, r_out_last;
    logic [width-1:0]   r_out_re, r_out_im;
    logic [N-1:0]       r_out_idx;
    logic               r_skid_vld;
    logic [2*width-1:0] r_skid_data;
    logic [N-1:0]       r_skid_idx;

    logic               r_ovf, r_sync_err;

    logic               w_pop, w_space;
    logic [2:0]         w_occ;
    logic               w_take_skid, w_take_rd_head, w_rd_to_skid;

    // ------------------------------------------------------------------
    // Write address mapping
    // ------------------------------------------------------------------
`ifdef FFT_UNLOAD_BITREV_EN
    for (genvar i = 0; i < N; i++) begin : g_bitrev
        assign w_wr_addr[i] = in_cnt[N-1-i];
    end
`else
    assign w_wr_addr = in_cnt;
`endif

    // ------------------------------------------------------------------
    // Output skid accounting: words held in head + skid + the RAM read
    // in flight. A new read is issued only if that word is guaranteed a
    // slot one cycle later even if nothing is popped meanwhile.
    // ------------------------------------------------------------------
    assign w_pop   = r_out_valid & out_ready;
    assign w_occ   = 3'(r_out_valid) + 3'(r_skid_vld) + 3'(r_rd_vld);
    assign w_space = (w_occ < (w_pop ? 3'd3 : 3'd2));

    // ------------------------------------------------------------------
    // Read FSM. The bank is released as soon as its last address has
    // been fetched: every remaining word then lives in the output
    // pipeline, so the write side may refill the bank immediately. This
    // keeps back-to-back frames flowing without drops.
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_issue     = 1'b0;
        w_rd_release   = 1'b0;
        w_rd_addr      = r_rd_addr;
        case (r_rd_state)
            RD_IDLE: begin
                if (r_bank[r_rd_ptr] == BANK_FULL) begin
                    w_rd_state_nxt = RD_PRIME;
                end
            end
            RD_PRIME: begin
                if (w_space) begin
                    w_rd_issue     = 1'b1;
                    w_rd_addr      = '0;
                    w_rd_state_nxt = RD_STREAM;
                end
            end
            RD_STREAM: begin
                if (w_space) begin
                    w_rd_issue = 1'b1;
                    if (r_rd_addr == c_LAST_IDX) begin
                        w_rd_release   = 1'b1;
                        w_rd_state_nxt = (r_bank[~r_rd_ptr] == BANK_FULL) ? RD_PRIME : RD_IDLE;
                    end
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Write side and bank bookkeeping. A release is applied first so a
    // frame start into the bank being released in the same cycle wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_bank_nxt[0] = r_bank[0];
        w_bank_nxt[1] = r_bank[1];
        w_wr_ptr_nxt  = r_wr_ptr;
        w_filling_nxt = r_filling;
        w_exp_cnt_nxt = r_exp_cnt;
        w_we          = 1'b0;
        w_abort       = 1'b0;
        w_drop        = 1'b0;

        if (w_rd_release) begin
            w_bank_nxt[r_rd_ptr] = BANK_FREE;
        end

        if (in_en) begin
            if (!r_filling) begin
                if (in_cnt == '0) begin
                    if ((r_bank[r_wr_ptr] == BANK_FREE) ||
                        (w_rd_release && (r_rd_ptr == r_wr_ptr))) begin
                        w_we                  = 1'b1;
                        w_filling_nxt         = 1'b1;
                        w_exp_cnt_nxt         = c_ONE;
                        w_bank_nxt[r_wr_ptr]  = BANK_FILLING;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end else if (in_cnt == r_exp_cnt) begin
                w_we          = 1'b1;
                w_exp_cnt_nxt = r_exp_cnt + c_ONE;
                if (in_cnt == c_LAST_IDX) begin
                    w_bank_nxt[r_wr_ptr] = BANK_FULL;
                    w_filling_nxt        = 1'b0;
                    w_wr_ptr_nxt         = ~r_wr_ptr;
                end
            end else begin
                w_abort              = 1'b1;
                w_filling_nxt        = 1'b0;
                w_bank_nxt[r_wr_ptr] = BANK_FREE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (areset) begin
            r_bank[0]  <= BANK_FREE;
            r_bank[1]  <= BANK_FREE;
            r_wr_ptr   <= 1'b0;
            r_filling  <= 1'b0;
            r_exp_cnt  <= '0;
            r_rd_state <= RD_IDLE;
            r_rd_ptr   <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_idx   <= '0;
            r_ovf      <= 1'b0;
            r_sync_err <= 1'b0;
        end else begin
            r_bank[0]  <= w_bank_nxt[0];
            r_bank[1]  <= w_bank_nxt[1];
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_filling  <= w_filling_nxt;
            r_exp_cnt  <= w_exp_cnt_nxt;
            r_rd_state <= w_rd_state_nxt;
            if (w_rd_release) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_rd_issue) begin
                r_rd_addr <= w_rd_addr + c_ONE;
                r_rd_idx  <= w_rd_addr;
            end
            r_rd_vld   <= w_rd_issue;
            r_ovf      <= r_ovf | w_drop;
            r_sync_err <= w_abort;
        end
    end

    // ------------------------------------------------------------------
    // Frame RAM: one write port, one registered read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[{r_wr_ptr, w_wr_addr}] <= {in_re, in_im};
        end
        if (w_rd_issue) begin
            r_rd_data <= r_mem[{r_rd_ptr, w_rd_addr}];
        end
    end

    // ------------------------------------------------------------------
    // Output head register plus one skid entry
    // ------------------------------------------------------------------
    assign w_take_skid    = w_pop & r_skid_vld;
    assign w_take_rd_head = r_rd_vld & ((w_pop & ~r_skid_vld) | ~r_out_valid);
    assign w_rd_to_skid   = r_rd_vld & ~w_take_rd_head;

    always_ff @(posedge clk) begin
        if (areset) begin
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_skid_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_idx  <= '0;
        end else begin
            r_out_valid <= (r_out_valid & ~w_pop) | w_take_skid | w_take_rd_head;
            r_skid_vld  <= (r_skid_vld & ~w_take_skid) | w_rd_to_skid;
            if (w_take_skid) begin
                r_out_re   <= r_skid_data[2*width-1:width];
                r_out_im   <= r_skid_data[width-1:0];
                r_out_idx  <= r_skid_idx;
                r_out_last <= &r_skid_idx;
            end else if (w_take_rd_head) begin
                r_out_re   <= r_rd_data[2*width-1:width];
                r_out_im   <= r_rd_data[width-1:0];
                r_out_idx  <= r_rd_idx;
                r_out_last <= &r_rd_idx;
            end
            if (w_rd_to_skid) begin
                r_skid_data <= r_rd_data;
                r_skid_idx  <= r_rd_idx;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_re    = r_out_re;
    assign out_im    = r_out_im;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign ovf       = r_ovf;
    assign sync_err  = r_sync_err;

endmodule
`default_nettype wire
